// File: rtl/dmem_access_ctrl_pkg.sv
// Shared memory-stage definitions: FSM state encoding and data-path widths.
// The store word is the store-data mux output: BOT_WIDTH bottom bits plus TOP_WIDTH top bits.
package dmem_access_ctrl_pkg;
  localparam int BOT_WIDTH   = 8;
  localparam int TOP_WIDTH   = 4;
  localparam int DMEM_ADDR_W = 12;
  localparam int DMEM_DATA_W = BOT_WIDTH + TOP_WIDTH;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } dmem_state_e;
endpackage

// File: rtl/dmem_timeout_ctr.sv
// BUSY-cycle watchdog for the data-memory port.
// hit_o is asserted while the current cycle is the LIMIT-th counted cycle.
module dmem_timeout_ctr #(
  parameter int LIMIT = 15
) (
  input  logic clock,
  input  logic reset,
  input  logic clr_i,
  input  logic en_i,
  output logic hit_o
);
  localparam int CW = $clog2(LIMIT + 1);

  logic [CW-1:0] cnt_q;

  // Saturating count, so a stray enable after the limit cannot wrap it.
  always_ff @(posedge clock) begin
    if (reset)                              cnt_q <= '0;
    else if (clr_i)                         cnt_q <= '0;
    else if (en_i && (cnt_q != CW'(LIMIT))) cnt_q <= cnt_q + 1'b1;
  end

  assign hit_o = (cnt_q == CW'(LIMIT - 1));
endmodule

// File: rtl/dmem_access_ctrl.sv
// Memory-stage data-memory access controller: one req/ack transaction per access, stalls until done.
// Optional BUSY timeout abort is enabled with `define DMEM_TIMEOUT_EN.
module dmem_access_ctrl
  import dmem_access_ctrl_pkg::*;
#(
  parameter int ADDR_WIDTH     = DMEM_ADDR_W,
  parameter int DATA_WIDTH     = DMEM_DATA_W,
  parameter int TIMEOUT_CYCLES = 15
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  mem_req_valid,
  input  logic                  mem_we,
  input  logic [ADDR_WIDTH-1:0] mem_addr,
  input  logic [DATA_WIDTH-1:0] mem_data,
  output logic                  pipeline_stall,
  output logic [DATA_WIDTH-1:0] rd_data,
  output logic                  rd_valid,
  output logic                  bus_error,
  output logic                  dmem_req,
  output logic                  dmem_we,
  output logic [ADDR_WIDTH-1:0] dmem_addr,
  output logic [DATA_WIDTH-1:0] dmem_wdata,
  input  logic                  dmem_ack,
  input  logic [DATA_WIDTH-1:0] dmem_rdata
);
  dmem_state_e           state_q;
  logic                  req_q, we_q, rd_valid_q, bus_error_q;
  logic [ADDR_WIDTH-1:0] addr_q;
  logic [DATA_WIDTH-1:0] wdata_q, rd_data_q;
  logic                  to_hit;

`ifdef DMEM_TIMEOUT_EN
  dmem_timeout_ctr #(.LIMIT(TIMEOUT_CYCLES)) u_timeout (
    .clock (clock),
    .reset (reset),
    .clr_i (state_q == IDLE && mem_req_valid),
    .en_i  (state_q == BUSY && !dmem_ack),
    .hit_o (to_hit)
  );
`else
  assign to_hit = 1'b0;
`endif

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q     <= IDLE;
      req_q       <= 1'b0;
      we_q        <= 1'b0;
      addr_q      <= '0;
      wdata_q     <= '0;
      rd_data_q   <= '0;
      rd_valid_q  <= 1'b0;
      bus_error_q <= 1'b0;
    end else begin
      rd_valid_q  <= 1'b0;
      bus_error_q <= 1'b0;
      case (state_q)
        IDLE: if (mem_req_valid) begin
          addr_q  <= mem_addr;
          we_q    <= mem_we;
          wdata_q <= mem_data;
          req_q   <= 1'b1;
          state_q <= BUSY;
        end
        BUSY: begin
          // An ack in the limit cycle takes priority over the abort.
          if (dmem_ack) begin
            req_q   <= 1'b0;
            state_q <= DONE;
            if (!we_q) begin
              rd_data_q  <= dmem_rdata;
              rd_valid_q <= 1'b1;
            end
          end else if (to_hit) begin
            req_q       <= 1'b0;
            state_q     <= DONE;
            bus_error_q <= 1'b1;
          end
        end
        DONE:    state_q <= IDLE;
        default: state_q <= IDLE;
      endcase
    end
  end

  assign pipeline_stall = (state_q == IDLE && mem_req_valid) || (state_q == BUSY);
  assign dmem_req       = req_q;
  assign dmem_we        = we_q;
  assign dmem_addr      = addr_q;
  assign dmem_wdata     = wdata_q;
  assign rd_data        = rd_data_q;
  assign rd_valid       = rd_valid_q;
  assign bus_error      = bus_error_q;
endmodule

// File: tb/tb_dmem_access_ctrl.sv
// Directed bench for dmem_access_ctrl: store/load latency, back-to-back, reset abandon, stray acks, timeout.
module tb_dmem_access_ctrl;
  logic        clock = 1'b0;
  logic        reset;
  logic        mem_req_valid, mem_we;
  logic [11:0] mem_addr, mem_data;
  logic        pipeline_stall, rd_valid, bus_error;
  logic [11:0] rd_data;
  logic        dmem_req, dmem_we, dmem_ack;
  logic [11:0] dmem_addr, dmem_wdata, dmem_rdata;

  int          n_cmp = 0;
  int          n_err = 0;
  logic [11:0] exp_rd = 12'h000;

  always #5 clock = ~clock;

  dmem_access_ctrl dut (
    .clock          (clock),
    .reset          (reset),
    .mem_req_valid  (mem_req_valid),
    .mem_we         (mem_we),
    .mem_addr       (mem_addr),
    .mem_data       (mem_data),
    .pipeline_stall (pipeline_stall),
    .rd_data        (rd_data),
    .rd_valid       (rd_valid),
    .bus_error      (bus_error),
    .dmem_req       (dmem_req),
    .dmem_we        (dmem_we),
    .dmem_addr      (dmem_addr),
    .dmem_wdata     (dmem_wdata),
    .dmem_ack       (dmem_ack),
    .dmem_rdata     (dmem_rdata)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  // One access starting in IDLE; ack on the (wait_cyc+1)-th BUSY cycle. Returns in the IDLE cycle after DONE.
  task automatic run_access(input string tg, input logic we, input logic [11:0] a, input logic [11:0] d,
                            input int wait_cyc, input logic [11:0] rdat, input logic hold_valid);
    int stalls = 0;
    mem_req_valid = 1'b1; mem_we = we; mem_addr = a; mem_data = d; dmem_ack = 1'b0;
    #1;
    chk({tg, "_idle_req"}, dmem_req, 0);
    if (pipeline_stall) stalls++;
    step();
    for (int i = 0; i <= wait_cyc; i++) begin
      dmem_ack   = (i == wait_cyc);
      dmem_rdata = (i == wait_cyc) ? rdat : 12'hFFF;
      #1;
      chk({tg, "_req"}, dmem_req, 1);
      chk({tg, "_we"}, dmem_we, we);
      chk({tg, "_addr"}, dmem_addr, a);
      if (we) chk({tg, "_wdata"}, dmem_wdata, d);
      if (pipeline_stall) stalls++;
      step();
    end
    dmem_ack = 1'b0;
    if (!hold_valid) mem_req_valid = 1'b0;
    if (!we) exp_rd = rdat;
    #1;
    chk({tg, "_done_stall"}, pipeline_stall, 0);
    chk({tg, "_done_req"}, dmem_req, 0);
    chk({tg, "_rd_valid"}, rd_valid, !we);
    chk({tg, "_rd_data"}, rd_data, exp_rd);
    chk({tg, "_bus_err"}, bus_error, 0);
    chk({tg, "_stalls"}, stalls, wait_cyc + 2);
    step();
    chk({tg, "_post_rv"}, rd_valid, 0);
    chk({tg, "_post_req"}, dmem_req, 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int busy;
    reset = 1'b1; mem_req_valid = 1'b0; mem_we = 1'b0; mem_addr = '0; mem_data = '0;
    dmem_ack = 1'b0; dmem_rdata = '0;
    step(); step(); step();
    chk("rst_req", dmem_req, 0);
    chk("rst_we", dmem_we, 0);
    chk("rst_addr", dmem_addr, 0);
    chk("rst_wdata", dmem_wdata, 0);
    chk("rst_rd_data", rd_data, 0);
    chk("rst_rd_valid", rd_valid, 0);
    chk("rst_bus_err", bus_error, 0);
    chk("rst_stall", pipeline_stall, 0);
    reset = 1'b0;
    step();

    run_access("st_imm", 1'b1, 12'h01A, 12'hABC, 0, 12'h000, 1'b0);
    run_access("ld_dly", 1'b0, 12'h200, 12'h000, 2, 12'h5A3, 1'b0);

    // Back-to-back: valid held through DONE, next request must wait one IDLE cycle.
    run_access("b2b_ld", 1'b0, 12'h0F0, 12'h000, 1, 12'h321, 1'b1);
    chk("b2b_gap_stall", pipeline_stall, 1);
    run_access("b2b_st", 1'b1, 12'h0F1, 12'h456, 0, 12'h000, 1'b0);

    // Stray ack while idle.
    dmem_ack = 1'b1; dmem_rdata = 12'h777;
    step(); step();
    chk("spur_rv", rd_valid, 0);
    chk("spur_req", dmem_req, 0);
    chk("spur_stall", pipeline_stall, 0);
    chk("spur_rd_data", rd_data, exp_rd);
    dmem_ack = 1'b0;

    // Reset mid-BUSY, then a late ack.
    mem_req_valid = 1'b1; mem_we = 1'b0; mem_addr = 12'h0AA;
    step(); step(); step();
    chk("rmb_req_before", dmem_req, 1);
    reset = 1'b1; mem_req_valid = 1'b0;
    step();
    chk("rmb_req", dmem_req, 0);
    chk("rmb_addr", dmem_addr, 0);
    chk("rmb_rd_data", rd_data, 0);
    chk("rmb_stall", pipeline_stall, 0);
    exp_rd = 12'h000;
    reset = 1'b0; dmem_ack = 1'b1; dmem_rdata = 12'h9C9;
    step();
    chk("rmb_late_rv", rd_valid, 0);
    chk("rmb_late_req", dmem_req, 0);
    chk("rmb_late_rd", rd_data, 0);
    dmem_ack = 1'b0;
    step();
    run_access("after_rst", 1'b0, 12'h3FF, 12'h000, 0, 12'h1E1, 1'b0);

`ifdef DMEM_TIMEOUT_EN
    mem_req_valid = 1'b1; mem_we = 1'b0; mem_addr = 12'h123; dmem_ack = 1'b0;
    step();
    busy = 0;
    for (int i = 0; i < 40 && dmem_req; i++) begin
      busy++;
      step();
    end
    mem_req_valid = 1'b0;
    chk("to_busy_cycles", busy, 15);
    chk("to_bus_err", bus_error, 1);
    chk("to_rd_valid", rd_valid, 0);
    chk("to_rd_data", rd_data, exp_rd);
    step();
    chk("to_bus_err_clr", bus_error, 0);
    run_access("to_ack15", 1'b0, 12'h124, 12'h000, 14, 12'h0B5, 1'b0);
`else
    mem_req_valid = 1'b1; mem_we = 1'b0; mem_addr = 12'h123; dmem_ack = 1'b0;
    step();
    for (int i = 0; i < 30; i++) step();
    chk("nto_req_held", dmem_req, 1);
    chk("nto_stall", pipeline_stall, 1);
    chk("nto_bus_err", bus_error, 0);
    dmem_ack = 1'b1; dmem_rdata = 12'h0B5;
    step();
    dmem_ack = 1'b0; mem_req_valid = 1'b0;
    chk("nto_rv", rd_valid, 1);
    chk("nto_rd_data", rd_data, 12'h0B5);
    chk("nto_bus_err_done", bus_error, 0);
    step();
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
